// File: rtl/lp_filter_pkg.sv
// Shared constants, coefficient/state types and the saturation helper for the
// multi-channel low-pass filter.
package lp_filter_pkg;

  localparam int COEF_W    = 35;
  localparam int STATE_W   = 35;
  localparam int FRAC_BITS = 32;

  localparam logic COEF_SEL_B0 = 1'b0;
  localparam logic COEF_SEL_A1 = 1'b1;

  typedef logic signed [COEF_W-1:0]  coef_t;
  typedef logic signed [STATE_W-1:0] state_t;

  // Clip a sign-extended value to the signed range of 'width' bits; result stays sign-extended.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/lp_filter_mc_if.sv
// Sample stream, coefficient load and filtered output bundle of lp_filter_mc.
// The filter is the slave; whoever feeds samples and coefficients is the master.
interface lp_filter_mc_if #(
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int CHANNELS        = 4
);
  import lp_filter_pkg::*;

  localparam int CH_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0]               on_in;
  logic                              valid_in;
  logic [CH_W-1:0]                   ch_in;
  logic signed [SIGNAL_IN_SIZE-1:0]  signal_in;
  logic                              coef_wr_in;
  logic [CH_W-1:0]                   coef_ch_in;
  logic                              coef_sel_in;
  coef_t                             coef_data_in;
  logic                              coef_commit_in;
  logic                              valid_out;
  logic [CH_W-1:0]                   ch_out;
  logic signed [SIGNAL_OUT_SIZE-1:0] signal_out;
  logic                              sat_out;

  modport master (
    output on_in, valid_in, ch_in, signal_in,
    output coef_wr_in, coef_ch_in, coef_sel_in, coef_data_in, coef_commit_in,
    input  valid_out, ch_out, signal_out, sat_out
  );

  modport slave (
    input  on_in, valid_in, ch_in, signal_in,
    input  coef_wr_in, coef_ch_in, coef_sel_in, coef_data_in, coef_commit_in,
    output valid_out, ch_out, signal_out, sat_out
  );

endinterface

// File: rtl/lp_coef_bank.sv
// Double-buffered per-channel b0/a1 coefficients: writes land in the shadow set,
// a commit copies the whole shadow set (including a same-edge write) to the active set.
module lp_coef_bank
  import lp_filter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            i_wr,
  input  logic [CH_W-1:0] i_wr_ch,
  input  logic            i_sel,
  input  coef_t           i_data,
  input  logic            i_commit,
  input  logic [CH_W-1:0] i_rd_ch,
  output coef_t           o_b0,
  output coef_t           o_a1
);

  coef_t r_b0_sh  [CHANNELS];
  coef_t r_a1_sh  [CHANNELS];
  coef_t r_b0_act [CHANNELS];
  coef_t r_a1_act [CHANNELS];
  coef_t w_b0_next [CHANNELS];
  coef_t w_a1_next [CHANNELS];
  logic  w_rd_ok;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_b0_next[i] = r_b0_sh[i];
      w_a1_next[i] = r_a1_sh[i];
      if (i_wr && (int'(i_wr_ch) == i)) begin
        if (i_sel == COEF_SEL_A1) w_a1_next[i] = i_data;
        else                      w_b0_next[i] = i_data;
      end
    end
  end

  // Commit copies the post-write shadow view so a write at the commit edge is included.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_b0_sh[i]  <= '0;
        r_a1_sh[i]  <= '0;
        r_b0_act[i] <= '0;
        r_a1_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_b0_sh[i] <= w_b0_next[i];
        r_a1_sh[i] <= w_a1_next[i];
        if (i_commit) begin
          r_b0_act[i] <= w_b0_next[i];
          r_a1_act[i] <= w_a1_next[i];
        end
      end
    end
  end

  assign w_rd_ok = (int'(i_rd_ch) < CHANNELS);
  assign o_b0    = w_rd_ok ? r_b0_act[i_rd_ch] : '0;
  assign o_a1    = w_rd_ok ? r_a1_act[i_rd_ch] : '0;

endmodule

// File: rtl/lp_filter_mc.sv
// Time-multiplexed multi-channel first-order IIR low-pass:
// y[ch] = sat35((a1*y[ch] + b0*x) >>> 32), three register stages, 2-cycle latency.
module lp_filter_mc
  import lp_filter_pkg::*;
#(
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int CHANNELS        = 4
) (
  input logic           clk_in,
  input logic           rst_in,
  lp_filter_mc_if.slave bus
);

  localparam int CH_W     = $clog2(CHANNELS);
  localparam int SOUT_LSB = 32 - SIGNAL_OUT_SIZE;

  logic signed [31:0]          w_xs;
  logic                        w_cap;
  coef_t                       w_b0;
  coef_t                       w_a1;
  logic signed [69:0]          w_b0x;

  logic                        r_v1;
  logic                        r_on1;
  logic [CH_W-1:0]             r_ch1;
  logic [SIGNAL_OUT_SIZE-1:0]  r_pass1;
  coef_t                       r_a1_1;
  logic signed [69:0]          r_b0x1;

  state_t                      r_y [CHANNELS];
  state_t                      w_y_cur;
  logic signed [69:0]          w_ay;
  logic signed [69:0]          w_sum;
  logic signed [37:0]          w_s;
  logic signed [63:0]          w_y_sat;
  logic                        w_sat35;

  logic                        r_v2;
  logic                        r_on2;
  logic [CH_W-1:0]             r_ch2;
  logic [SIGNAL_OUT_SIZE-1:0]  r_pass2;
  state_t                      r_y2;
  logic                        r_sat2;

  logic signed [63:0]          w_o32;
  logic                        w_sat32;
  logic                        r_valid_out;
  logic [CH_W-1:0]             r_ch_out;
  logic [SIGNAL_OUT_SIZE-1:0]  r_signal_out;
  logic                        r_sat_out;

  lp_coef_bank #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_coef_bank (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_wr     (bus.coef_wr_in),
    .i_wr_ch  (bus.coef_ch_in),
    .i_sel    (bus.coef_sel_in),
    .i_data   (bus.coef_data_in),
    .i_commit (bus.coef_commit_in),
    .i_rd_ch  (bus.ch_in),
    .o_b0     (w_b0),
    .o_a1     (w_a1)
  );

  assign w_xs  = 32'(bus.signal_in) <<< (32 - SIGNAL_IN_SIZE);
  assign w_cap = bus.valid_in && (int'(bus.ch_in) < CHANNELS);
  assign w_b0x = 70'(w_b0) * 70'(w_xs);

  // a1 is captured with b0x so a commit between stages cannot mix coefficient sets.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_v1    <= 1'b0;
      r_on1   <= 1'b0;
      r_ch1   <= '0;
      r_pass1 <= '0;
      r_a1_1  <= '0;
      r_b0x1  <= '0;
    end else begin
      r_v1    <= w_cap;
      r_on1   <= bus.on_in[bus.ch_in];
      r_ch1   <= bus.ch_in;
      r_pass1 <= w_xs[31:SOUT_LSB];
      r_a1_1  <= w_a1;
      r_b0x1  <= w_b0x;
    end
  end

  assign w_y_cur = r_y[r_ch1];
  assign w_ay    = 70'(r_a1_1) * 70'(w_y_cur);
  assign w_sum   = w_ay + r_b0x1;
  assign w_s     = 38'(w_sum >>> FRAC_BITS);
  assign w_y_sat = saturate(64'(w_s), STATE_W);
  assign w_sat35 = (w_y_sat != 64'(w_s));

  // y[ch] is read and written here, so back-to-back samples of one channel chain directly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < CHANNELS; i++) r_y[i] <= '0;
      r_v2    <= 1'b0;
      r_on2   <= 1'b0;
      r_ch2   <= '0;
      r_pass2 <= '0;
      r_y2    <= '0;
      r_sat2  <= 1'b0;
    end else begin
      r_v2    <= r_v1;
      r_on2   <= r_on1;
      r_ch2   <= r_ch1;
      r_pass2 <= r_pass1;
      r_y2    <= w_y_sat[STATE_W-1:0];
      r_sat2  <= r_on1 && w_sat35;
      if (r_v1) r_y[r_ch1] <= r_on1 ? w_y_sat[STATE_W-1:0] : '0;
    end
  end

  assign w_o32   = saturate(64'(r_y2), 32);
  assign w_sat32 = (w_o32 != 64'(r_y2));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid_out  <= 1'b0;
      r_ch_out     <= '0;
      r_signal_out <= '0;
      r_sat_out    <= 1'b0;
    end else begin
      r_valid_out <= r_v2;
      if (r_v2) begin
        r_ch_out <= r_ch2;
        if (r_on2) begin
          r_signal_out <= w_o32[31:SOUT_LSB];
          r_sat_out    <= r_sat2 || w_sat32;
        end else begin
          r_signal_out <= r_pass2;
          r_sat_out    <= 1'b0;
        end
      end
    end
  end

  assign bus.valid_out  = r_valid_out;
  assign bus.ch_out     = r_ch_out;
  assign bus.signal_out = r_signal_out;
  assign bus.sat_out    = r_sat_out;

endmodule

// File: tb/tb_lp_filter_mc.sv
// Directed bench for lp_filter_mc: hand-computed outputs are queued per captured
// sample and compared two cycles later with immediate assertions.
module tb_lp_filter_mc;
  import lp_filter_pkg::*;

  localparam int SIN  = 16;
  localparam int SOUT = 16;
  localparam int CH   = 4;
  localparam int CH_W = $clog2(CH);

  localparam coef_t ONE   = 35'sd4294967296;
  localparam coef_t HALF  = 35'sd2147483648;
  localparam coef_t THREE = 35'sd12884901888;

  typedef struct {
    logic v;
    logic chk;
    int   ch;
    int   sig;
    logic sat;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    total = 0;
  int    bad   = 0;
  exp_t  expQ[$];
  string tagQ[$];

  lp_filter_mc_if #(.SIGNAL_IN_SIZE(SIN), .SIGNAL_OUT_SIZE(SOUT), .CHANNELS(CH)) bus ();

  lp_filter_mc #(
    .SIGNAL_IN_SIZE  (SIN),
    .SIGNAL_OUT_SIZE (SOUT),
    .CHANNELS        (CH)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkEq({tag, ".valid"}, bus.valid_out, e.v);
    if (e.chk) begin
      checkEq({tag, ".ch"}, bus.ch_out, e.ch);
      checkEq({tag, ".sig"}, bus.signal_out, e.sig);
    end
    if (e.chk && e.v) checkEq({tag, ".sat"}, bus.sat_out, e.sat);
  endtask

  // One capture edge; the output for the sample driven two calls earlier is then checked.
  task automatic applyStimulus(input logic v, input int ch, input int x, input logic chk,
                               input int expCh, input int expSig, input logic expSat, input string tag);
    exp_t  e;
    exp_t  old;
    string oldTag;
    bus.valid_in  = v;
    bus.ch_in     = CH_W'(ch);
    bus.signal_in = SIN'(x);
    @(posedge clk);
    #1;
    bus.valid_in       = 1'b0;
    bus.coef_wr_in     = 1'b0;
    bus.coef_commit_in = 1'b0;
    e.v   = v;
    e.chk = chk;
    e.ch  = expCh;
    e.sig = expSig;
    e.sat = expSat;
    expQ.push_back(e);
    tagQ.push_back(tag);
    if (expQ.size() == 3) begin
      old    = expQ.pop_front();
      oldTag = tagQ.pop_front();
      checkOutput(old, oldTag);
    end
  endtask

  task automatic sample(input int ch, input int x, input int expSig, input string tag);
    applyStimulus(1'b1, ch, x, 1'b1, ch, expSig, 1'b0, tag);
  endtask

  task automatic sampleSat(input int ch, input int x, input int expSig, input string tag);
    applyStimulus(1'b1, ch, x, 1'b1, ch, expSig, 1'b1, tag);
  endtask

  task automatic bubble(input string tag);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, tag);
  endtask

  task automatic setCoef(input int ch, input logic sel, input coef_t data);
    bus.coef_wr_in   = 1'b1;
    bus.coef_ch_in   = CH_W'(ch);
    bus.coef_sel_in  = sel;
    bus.coef_data_in = data;
  endtask

  task automatic setCommit();
    bus.coef_commit_in = 1'b1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.on_in          = '1;
    bus.valid_in       = 1'b0;
    bus.ch_in          = '0;
    bus.signal_in      = '0;
    bus.coef_wr_in     = 1'b0;
    bus.coef_ch_in     = '0;
    bus.coef_sel_in    = 1'b0;
    bus.coef_data_in   = '0;
    bus.coef_commit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("reset.valid", bus.valid_out, 0);
    checkEq("reset.ch", bus.ch_out, 0);
    checkEq("reset.sig", bus.signal_out, 0);
    checkEq("reset.sat", bus.sat_out, 0);
    rst = 1'b0;

    // ch0 unity passthrough
    setCoef(0, COEF_SEL_B0, ONE);
    bubble("cfg_b0");
    setCommit();
    bubble("cfg_commit");
    sample(0, 1000, 1000, "pass_pos");
    sample(0, -1000, -1000, "pass_neg");

    // ch0/ch1 a1 = b0 = 0.5; last write shares the commit edge
    setCoef(0, COEF_SEL_A1, HALF);
    bubble("cfg_a1_0");
    setCoef(0, COEF_SEL_B0, HALF);
    bubble("cfg_b0_0");
    setCoef(1, COEF_SEL_A1, HALF);
    bubble("cfg_a1_1");
    setCoef(1, COEF_SEL_B0, HALF);
    setCommit();
    bubble("cfg_b0_1_commit");

    bus.on_in[0] = 1'b0;
    sample(0, 5, 5, "off_ch0");
    bus.on_in[0] = 1'b1;

    sample(0, 16384, 8192,  "il_ch0_1");
    sample(1, 16384, 8192,  "il_ch1_1");
    sample(0, 16384, 12288, "il_ch0_2");
    sample(1, 16384, 12288, "il_ch1_2");
    sample(0, 16384, 14336, "il_ch0_3");
    sample(1, 16384, 14336, "il_ch1_3");

    bus.on_in[1] = 1'b0;
    sample(1, 7, 7, "off_ch1");
    bus.on_in[1] = 1'b1;

    sample(1, 16384, 8192,  "step_1");
    sample(1, 16384, 12288, "step_2");
    sample(1, 16384, 14336, "step_3");
    sample(1, 16384, 15360, "step_4");

    // ch3 b0 = 3.0 drives the output past full scale
    setCoef(3, COEF_SEL_B0, THREE);
    setCommit();
    bubble("cfg_ch3");
    sampleSat(3, 32767, 32767, "sat_pos");
    sampleSat(3, -32768, -32768, "sat_neg");

    setCoef(3, COEF_SEL_B0, ONE);
    sample(3, 1000, 3000, "shadow_wr");
    sample(3, 1000, 3000, "shadow_hold");
    setCommit();
    sample(3, 1000, 3000, "commit_edge");
    sample(3, 1000, 1000, "after_commit");

    bus.on_in[2] = 1'b0;
    sample(2, 123, 123, "off_ch2");
    bus.on_in[2] = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b1, 2, 123, 1'b0, "hold_1");
    applyStimulus(1'b0, 0, 0, 1'b1, 2, 123, 1'b0, "hold_2");
    bubble("drain_1");
    bubble("drain_2");

    // reset while a ch1 sample is in flight
    applyStimulus(1'b1, 1, 16384, 1'b0, 1, 0, 1'b0, "inflight");
    bus.valid_in  = 1'b1;
    bus.ch_in     = CH_W'(1);
    bus.signal_in = SIN'(16384);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    checkEq("rst_mid.valid", bus.valid_out, 0);
    checkEq("rst_mid.sig", bus.signal_out, 0);
    checkEq("rst_mid.ch", bus.ch_out, 0);
    checkEq("rst_mid.sat", bus.sat_out, 0);
    expQ.delete();
    tagQ.delete();
    bubble("post_rst_b");
    checkEq("rst_drop.valid", bus.valid_out, 0);
    sample(0, 1000, 0, "post_rst_zero");
    bubble("final_1");
    bubble("final_2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lp_filter_mc.md
Name: lp_filter_mc

Overview:
Time-multiplexed, multi-channel first-order IIR low-pass filter. It is the parametrised successor to the single-channel low-pass block. It processes a stream of samples tagged by channel index, and keeps per-channel state, per-channel coefficients and a per-channel enable. It adds double-buffered coefficient loading with atomic commit, 35-bit state saturation and output saturation with a flag. It sits between the ADC demux and the servo loop filters, so one DSP chain serves CHANNELS inputs.

Parameters:
SIGNAL_IN_SIZE, 16, input sample width in bits (<= 32)
SIGNAL_OUT_SIZE, 16, output sample width in bits (>= SIGNAL_IN_SIZE, <= 32)
CHANNELS, 4, number of channels (2..16)
CH_W, $clog2(CHANNELS), channel index width (localparam, derived)

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst_in  in  1  synchronous, active-high reset
on_in  in  CHANNELS  per-channel filter enable
valid_in  in  1  sample strobe; no backpressure, one sample per cycle max
ch_in  in  CH_W  channel of the current sample
signal_in  in  SIGNAL_IN_SIZE  signed sample
coef_wr_in  in  1  write shadow coefficient
coef_ch_in  in  CH_W  shadow coefficient channel
coef_sel_in  in  1  0 = b0, 1 = a1
coef_data_in  in  35  signed coefficient, Q3.32
coef_commit_in  in  1  copy all shadow coefficients to active
valid_out  out  1  output strobe
ch_out  out  CH_W  channel of signal_out
signal_out  out  SIGNAL_OUT_SIZE  signed filtered sample
sat_out  out  1  the sample on signal_out was saturated (qualified by valid_out)

Behaviour:
- Reset (rst_in = 1 at an edge):
  - All per-channel y, shadow and active coefficients, and pipeline valids clear to 0.
  - valid_out, ch_out, signal_out and sat_out are 0.
  - rst_in overrides all other inputs; samples in flight are discarded.
- Stage 1 (edge k, valid_in = 1):
  - Register ch and x_s = signal_in <<< (32 - SIGNAL_IN_SIZE).
  - Register b0x = b0_act[ch] * x_s (70-bit).
  - Register a1_act[ch] alongside, so each sample uses one coherent coefficient set.
- Stage 2 (edge k+1):
  - s = (a1_s1 * y[ch] + b0x) >>> 32, computed at 38 bits.
  - y[ch] <= s saturated to the 35-bit signed range.
  - y[ch] is read and written in the same stage, so back-to-back samples of one channel chain correctly with no bubbles.
- Stage 3 (edge k+2), output:
  - valid_out = 1, ch_out = ch.
  - When on: signal_out = y_new saturated to the signed 32-bit range, then sliced [31:32-SIGNAL_OUT_SIZE].
  - sat_out = 1 if either saturation clipped.
  - Latency is exactly 2 cycles after the capture edge, for every channel and mode.
- Channel off (on_in[ch] = 0, sampled at stage 1):
  - y[ch] is cleared to 0 at stage 2.
  - signal_out = signal_in sign-extended and shifted left by (SIGNAL_OUT_SIZE - SIGNAL_IN_SIZE); sat_out = 0.
  - Same 2-cycle latency.
  - Deasserting on_in while the channel's sample is in flight affects only samples captured afterwards.
- valid_in = 0: the pipeline advances with a bubble; no y changes; valid_out = 0 two cycles later. signal_out and ch_out hold their previous values.
- Coefficient writes:
  - coef_wr_in writes the shadow register at the edge.
  - coef_commit_in copies all shadow registers to active at the edge.
  - Write and commit at the same edge: the written value is included in the commit.
  - A sample captured at the commit edge uses the old set; the new set applies from the next capture.
  - Commit never alters y.
- Out-of-range ch_in (>= CHANNELS): the sample is dropped; valid_out = 0 for that slot.

Decomposition:
- Package lp_filter_pkg holds:
  - COEF_W = 35, STATE_W = 35, FRAC_BITS = 32;
  - the COEF_SEL_B0/COEF_SEL_A1 constants;
  - the saturate function (input width to target width).
- One sub-module, lp_coef_bank, holds the shadow/active coefficient arrays, the write/commit logic and the per-channel read.

Test Plan:
- Passthrough: on = all, a1 = 0, b0 = 2^32 (1.0), ch0 x = 1000 then -1000 -> signal_out = 1000, -1000 exactly 2 cycles later; sat_out = 0.
- Step: ch1 a1 = b0 = 2^31 (0.5), x = 16384 each cycle on ch1 -> outputs 8192, 12288, 14336, 15360, converging to 16384.
- Interleave: ch0 and ch1 configured as in the step test, alternating ch0/ch1/ch0..., x = 16384 -> each channel independently shows 8192, 12288, ...; ch_out matches the input order.
- Saturation: a1 = 0, b0 = 3*2^32, x = 32767 -> signal_out = 32767, sat_out = 1; with x = -32768 -> -32768, sat_out = 1.
- Commit atomicity: write shadow b0 = 2^32 during the stream without commit -> output unchanged. Commit at the capture edge of sample n -> sample n uses the old set, n+1 the new.
- Off/reset: on_in[2] = 0 -> x = 123 passes through as 123, y[2] = 0. Assert rst_in mid-stream -> valid_out = 0 and signal_out = 0 at the next edge; the first post-reset output uses zero coefficients (0).
